// File: rtl/square_wave_burst_ctrl.sv
// square_wave_burst_ctrl: runs a square-wave burst of count periods with run-time on/off lengths; optional abort via SQW_BURST_ABORT_EN
module square_wave_burst_ctrl #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_on_time,
    input  logic [N-1:0]  cmd_off_time,
    input  logic [CW-1:0] cmd_count,
`ifdef SQW_BURST_ABORT_EN
    input  logic          abort,
`endif
    output logic          s_wave,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pulses_left
);
    typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;
    state_t state;
    logic [N-1:0] on_r, off_r, timer;
    logic abort_hit, zero_cmd;
`ifdef SQW_BURST_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif
    assign zero_cmd = cmd_on_time == '0 || cmd_off_time == '0 || cmd_count == '0;
    // burst sequencer: all outputs registered alongside the state
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            on_r        <= '0;
            off_r       <= '0;
            timer       <= '0;
            s_wave      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_ready   <= 1'b1;
            pulses_left <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    on_r      <= cmd_on_time;
                    off_r     <= cmd_off_time;
                    timer     <= '0;
                    cmd_ready <= 1'b0;
                    if (zero_cmd) begin
                        state       <= FIN;
                        done        <= 1'b1;
                        pulses_left <= '0;
                    end else begin
                        state       <= ON;
                        s_wave      <= 1'b1;
                        busy        <= 1'b1;
                        pulses_left <= cmd_count;
                    end
                end
                ON: if (abort_hit) begin
                    state       <= FIN;
                    s_wave      <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    pulses_left <= '0;
                end else if (timer == on_r - 1'b1) begin
                    state  <= OFF;
                    timer  <= '0;
                    s_wave <= 1'b0;
                end else
                    timer <= timer + 1'b1;
                OFF: if (abort_hit || (timer == off_r - 1'b1 && pulses_left == CW'(1))) begin
                    state       <= FIN;
                    s_wave      <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    pulses_left <= '0;
                end else if (timer == off_r - 1'b1) begin
                    state       <= ON;
                    timer       <= '0;
                    s_wave      <= 1'b1;
                    pulses_left <= pulses_left - 1'b1;
                end else
                    timer <= timer + 1'b1;
                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
endmodule

// File: tb/tb_square_wave_burst_ctrl.sv
// tb_square_wave_burst_ctrl: random commands checked against a timing-formula model
module tb_square_wave_burst_ctrl;
    localparam int N  = 4;
    localparam int CW = 8;
`ifdef SQW_BURST_ABORT_EN
    localparam bit AB = 1'b1;
`else
    localparam bit AB = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
    logic [N-1:0] cmd_on_time = '0, cmd_off_time = '0;
    logic [CW-1:0] cmd_count = '0;
    logic cmd_ready, s_wave, busy, done;
    logic [CW-1:0] pulses_left;
    int checks = 0, failures = 0;
    bit m_active = 1'b0;
    int m_d = 0, m_on = 0, m_off = 0, m_cnt = 0, m_fin = 0;

    always #5 clk = ~clk;

    square_wave_burst_ctrl #(.N(N), .CW(CW)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_on_time(cmd_on_time),
        .cmd_off_time(cmd_off_time),
        .cmd_count(cmd_count),
`ifdef SQW_BURST_ABORT_EN
        .abort(abort),
`endif
        .s_wave(s_wave),
        .busy(busy),
        .done(done),
        .pulses_left(pulses_left)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, obs, exp);
        end
    endtask

    // expected outputs from cycle position d within the burst: d<fin runs periods, d==fin is done
    task automatic check_model;
        int e_s = 0, e_b = 0, e_d = 0, e_r = 1, e_p = 0, p;
        if (m_active) begin
            e_r = 0;
            if (m_d < m_fin) begin
                p   = m_on + m_off;
                e_b = 1;
                e_s = ((m_d - 1) % p) < m_on ? 1 : 0;
                e_p = m_cnt - (m_d - 1) / p;
            end else
                e_d = 1;
        end
        check("s_wave", 32'(s_wave), e_s);
        check("busy", 32'(busy), e_b);
        check("done", 32'(done), e_d);
        check("cmd_ready", 32'(cmd_ready), e_r);
        check("pulses_left", 32'(pulses_left), e_p);
    endtask

    task automatic step(input logic v, input logic [N-1:0] on, input logic [N-1:0] off,
                        input logic [CW-1:0] cnt, input logic ab);
        @(negedge clk);
        check_model();
        cmd_valid    = v;
        cmd_on_time  = on;
        cmd_off_time = off;
        cmd_count    = cnt;
        abort        = ab;
        if (!m_active && v) begin
            m_active = 1'b1;
            m_d      = 1;
            m_on     = int'(on);
            m_off    = int'(off);
            m_cnt    = int'(cnt);
            m_fin    = (on == 0 || off == 0 || cnt == 0) ? 1 : m_cnt * (m_on + m_off) + 1;
        end else if (m_active) begin
            if (AB && ab && m_d < m_fin) m_fin = m_d + 1;
            m_d++;
            if (m_d > m_fin) m_active = 1'b0;
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 200 && m_active; i++) step(1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        #8;
        check_model();
        #4 reset = 1'b0;
        step(1'b1, 4'd3, 4'd2, 8'd2, 1'b0);
        drain();
        step(1'b1, 4'd1, 4'd1, 8'd4, 1'b0);
        drain();
        step(1'b1, 4'd2, 4'd2, 8'd0, 1'b0);
        drain();
        step(1'b1, 4'd0, 4'd2, 8'd2, 1'b0);
        drain();
        step(1'b1, 4'd2, 4'd0, 8'd2, 1'b0);
        drain();
        step(1'b1, 4'd15, 4'd1, 8'd1, 1'b0);
        drain();
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4)),
                 4'($urandom_range(0, 4)),
                 8'($urandom_range(0, 3)),
                 1'($urandom_range(0, 19) == 0));
        drain();
        step(1'b1, 4'd4, 4'd4, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'd1, 4'd1, 8'd1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1);
        drain();
        step(1'b1, 4'd3, 4'd2, 8'd5, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_s_wave", 32'(s_wave), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_pulses", 32'(pulses_left), 0);
        m_active = 1'b0;
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 4'd2, 4'd1, 8'd2, 1'b0);
        drain();
        step(1'b0, '0, '0, '0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/square_wave_burst_ctrl.md
Name: square_wave_burst_ctrl

Overview:
- Sequencer for the square-wave datapath: accepts a command holding on-time, off-time and pulse count, then drives a square wave for exactly that many periods.
- Reports completion with a one-cycle done pulse.
- Sits between a control host or register block and the square-wave output pin.
- Replaces fixed on/off parameters with run-time values and a start/done handshake.

Parameters:
- N, 4, bit width of the on_time and off_time command fields and of the internal period timer.
- CW, 8, bit width of the pulse-count command field and of the remaining-pulse counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_on_time  input  N  high-phase length in clk cycles.
- cmd_off_time  input  N  low-phase length in clk cycles.
- cmd_count  input  CW  number of full periods (high then low).
- s_wave  output  1  registered square-wave output.
- busy  output  1  high while in ON or OFF.
- done  output  1  one-cycle pulse when the burst completes.
- pulses_left  output  CW  periods not yet started, including the one in progress.

Behaviour:
- Reset (async, any state): state=IDLE, s_wave=0, busy=0, done=0, cmd_ready=1, pulses_left=0, timer=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, ON, OFF, FIN.
- Acceptance occurs on a rising edge with cmd_valid=1 and cmd_ready=1 (state IDLE).
  - On acceptance the on/off/count fields are latched.
  - Later changes on the cmd_* inputs have no effect until the next acceptance.
- Zero command: if any of on_time, off_time or count is 0 at acceptance, the next state is FIN.
  - No pulse is generated and s_wave stays 0.
  - done=1 in the cycle after acceptance.
- Normal command, IDLE->ON at the acceptance edge: s_wave=1, busy=1, cmd_ready=0, timer=0, pulses_left=count.
- ON:
  - timer increments each cycle.
  - When timer==on_time-1: go to OFF, timer=0, s_wave=0.
  - s_wave is therefore high for exactly on_time cycles.
- OFF:
  - timer increments each cycle.
  - When timer==off_time-1 and pulses_left>1: go to ON, s_wave=1, pulses_left decrements.
  - When timer==off_time-1 and pulses_left==1: go to FIN, pulses_left=0, busy=0.
- FIN: lasts 1 cycle with done=1 and cmd_ready=0, then goes to IDLE with cmd_ready=1.
- Timing: for a command accepted at edge k, the s_wave first rising edge is at edge k; done is high during cycle k+count*(on+off)+1; cmd_ready returns one cycle later.
- Timer is N bits and never wraps, because the compare fires at most at 2^N-2.
  - on_time=2^N-1 is legal and gives 2^N-1 high cycles.
- cmd_valid while busy is ignored; it is not queued or latched.
- Reset mid-burst: s_wave drops to 0 asynchronously, no done pulse is generated, and the block is IDLE after reset is released.

Optional Feature:
- Macro SQW_BURST_ABORT_EN.
- Defined:
  - Adds an input port abort (1 bit).
  - abort=1 sampled in ON or OFF sends the next state to FIN: s_wave=0, busy=0, pulses_left=0, done pulses for 1 cycle as on normal completion.
  - abort in IDLE or FIN has no effect.
  - abort takes priority over a same-cycle ON/OFF phase transition.
- Undefined: no abort port exists; the burst always runs to completion or until reset.

Test Plan:
- Reset, then on=3, off=2, count=2 accepted at edge 0.
  - s_wave pattern from edge 0: 1,1,1,0,0,1,1,1,0,0.
  - done=1 during cycle 11; cmd_ready=1 from cycle 12; pulses_left reads 2,2,2,2,2,1,1,1,1,1.
- on=1, off=1, count=4.
  - 4 alternating single-cycle pulses, 8 cycles busy, then a single done pulse.
- count=0 (also repeat with on=0, then off=0).
  - s_wave stays 0, busy never asserts, done=1 exactly one cycle after acceptance.
- New cmd_valid with different fields asserted continuously during a burst.
  - It is ignored; the burst waveform is unchanged.
  - The held command is accepted when cmd_ready returns to 1.
- Assert reset asynchronously mid-ON of the 2nd pulse of a count=5 burst.
  - s_wave=0 immediately, no done pulse, cmd_ready=1 after release.
- With SQW_BURST_ABORT_EN defined, on=4, off=4, count=3, abort pulsed in cycle 6.
  - s_wave=0 from cycle 7, done=1 in cycle 7, pulses_left=0.
